// File: rtl/coef_block_builder.sv
`timescale 1ns/1ps
// coef_block_builder: expands decoded (run, size, value) symbols into 64
// zigzag-ordered quantized coefficients per 8x8 block. It applies the DC
// differential prediction for each colour component and drives a one-deep
// valid/ready output register.
module coef_block_builder #(
  parameter int NUM_COMP = 3,
  parameter int COEF_W   = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dc,
  input  logic [1:0]        in_comp,
  input  logic [3:0]        in_run,
  input  logic [3:0]        in_size,
  input  logic [COEF_W-1:0] in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [5:0]        out_idx,
  output logic [1:0]        out_comp,
  output logic              out_last,
  output logic              err
);

  typedef enum logic [2:0] {S_DC, S_AC, S_ZERO, S_VAL, S_FILL} state_t;

  localparam logic [2:0] NC = 3'(NUM_COMP);

  // Two's-complement wrap of the DC prediction sum.
  function automatic logic signed [COEF_W-1:0] wrap_add(
    input logic signed [COEF_W-1:0] a,
    input logic signed [COEF_W-1:0] b
  );
    return a + b;
  endfunction

  state_t                     state, state_d;
  logic [6:0]                 next_idx, next_idx_d;
  logic [4:0]                 zero_cnt, zero_cnt_d;
  logic signed [COEF_W-1:0]   pend, pend_d;
  logic                       pend_vld, pend_vld_d;
  logic [1:0]                 cur_comp;
  logic signed [COEF_W-1:0]   pred [NUM_COMP];

  logic                       slot_free;
  logic                       accept;
  logic                       is_eob;
  logic                       is_zrl;
  logic [1:0]                 comp_sel;
  logic signed [COEF_W-1:0]   in_val_s;
  logic signed [COEF_W-1:0]   pred_base;
  logic signed [COEF_W-1:0]   dc_coef;
  logic [7:0]                 span_ac;
  logic [7:0]                 span_zrl;
  logic                       emit;
  logic                       emit_last;
  logic signed [COEF_W-1:0]   emit_coef;
  logic                       err_set;
  logic                       pred_we;
  logic                       comp_we;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = ((state == S_DC) || (state == S_AC)) && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_eob    = (in_size == 4'd0) && (in_run == 4'd0);
  assign is_zrl    = (in_size == 4'd0) && (in_run == 4'd15);
  assign comp_sel  = ({1'b0, in_comp} < NC) ? in_comp : 2'd0;
  assign in_val_s  = in_value;
  assign pred_base = restart ? '0 : pred[comp_sel];
  assign dc_coef   = wrap_add(pred_base, in_val_s);
  assign span_ac   = {1'b0, next_idx} + {4'b0, in_run} + 8'd1;
  assign span_zrl  = {1'b0, next_idx} + 8'd16;

  // Next-state and coefficient selection; every emitted coefficient lands at next_idx.
  always_comb begin
    state_d    = state;
    next_idx_d = next_idx;
    zero_cnt_d = zero_cnt;
    pend_d     = pend;
    pend_vld_d = pend_vld;
    emit       = 1'b0;
    emit_coef  = '0;
    err_set    = 1'b0;
    pred_we    = 1'b0;
    comp_we    = 1'b0;
    emit_last  = 1'b0;

    case (state)
      S_DC: begin
        if (accept) begin
          if (in_dc) begin
            emit      = 1'b1;
            emit_coef = dc_coef;
            pred_we   = 1'b1;
            comp_we   = 1'b1;
            state_d   = S_AC;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_AC: begin
        if (accept) begin
          if (in_dc) begin
            err_set = 1'b1;
          end else if (is_eob) begin
            emit    = 1'b1;
            state_d = S_FILL;
          end else if (is_zrl) begin
            emit = 1'b1;
            if (span_zrl > 8'd64) begin
              err_set = 1'b1;
              state_d = S_FILL;
            end else begin
              zero_cnt_d = 5'd15;
              pend_vld_d = 1'b0;
              state_d    = S_ZERO;
            end
          end else begin
            emit = 1'b1;
            if (span_ac > 8'd64) begin
              // Run would pass idx 63: zero-fill the block and drop the value.
              err_set = 1'b1;
              state_d = S_FILL;
            end else if (in_run == 4'd0) begin
              emit_coef = in_val_s;
            end else begin
              zero_cnt_d = {1'b0, in_run} - 5'd1;
              pend_d     = in_val_s;
              pend_vld_d = 1'b1;
              state_d    = (in_run == 4'd1) ? S_VAL : S_ZERO;
            end
          end
        end
      end
      S_ZERO: begin
        if (slot_free) begin
          emit       = 1'b1;
          zero_cnt_d = zero_cnt - 5'd1;
          if (zero_cnt == 5'd1) state_d = pend_vld ? S_VAL : S_AC;
        end
      end
      S_VAL: begin
        if (slot_free) begin
          emit       = 1'b1;
          emit_coef  = pend;
          pend_vld_d = 1'b0;
          state_d    = S_AC;
        end
      end
      S_FILL: begin
        if (slot_free) emit = 1'b1;
      end
      default: state_d = S_DC;
    endcase

    // Emitting idx 63 closes the block whatever path produced it.
    if (emit) begin
      if (next_idx == 7'd63) begin
        emit_last  = 1'b1;
        state_d    = S_DC;
        next_idx_d = '0;
        zero_cnt_d = '0;
        pend_vld_d = 1'b0;
      end else begin
        next_idx_d = next_idx + 7'd1;
      end
    end
  end

  // FSM and run bookkeeping registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_DC;
      next_idx <= '0;
      zero_cnt <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      cur_comp <= '0;
    end else begin
      state    <= state_d;
      next_idx <= next_idx_d;
      zero_cnt <= zero_cnt_d;
      pend     <= pend_d;
      pend_vld <= pend_vld_d;
      if (comp_we) cur_comp <= in_comp;
    end
  end

  // DC predictors: an accepted DC write wins over a coincident restart clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COMP; i++) begin
        if (pred_we && (comp_sel == 2'(i))) pred[i] <= dc_coef;
        else if (restart)                   pred[i] <= '0;
      end
    end
  end

  // Sticky run-overflow / misplaced-symbol flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Output register stage: loads only when the slot is free, so fields hold under stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      out_comp  <= '0;
      out_last  <= 1'b0;
    end else if (slot_free) begin
      out_valid <= emit;
      out_last  <= emit_last;
      if (emit) begin
        out_coef <= emit_coef;
        out_idx  <= next_idx[5:0];
        out_comp <= comp_we ? in_comp : cur_comp;
      end
    end
  end

endmodule

// File: tb/tb_coef_block_builder.sv
`timescale 1ns/1ps
// Directed bench for coef_block_builder: symbols are driven in sequence and
// every handshaked output beat is captured, then compared with hand-computed blocks.
module tb_coef_block_builder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic        in_dc;
  logic [1:0]  in_comp;
  logic [3:0]  in_run;
  logic [3:0]  in_size;
  logic [11:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coef;
  logic [5:0]  out_idx;
  logic [1:0]  out_comp;
  logic        out_last;
  logic        err;

  typedef struct {
    int coef;
    int idx;
    int comp;
    int last;
  } beat_t;

  beat_t beats[$];
  int    exp_coef [64];
  int    checks = 0;
  int    errors = 0;

  coef_block_builder #(.NUM_COMP(3), .COEF_W(12)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .restart  (restart),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dc    (in_dc),
    .in_comp  (in_comp),
    .in_run   (in_run),
    .in_size  (in_size),
    .in_value (in_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_coef (out_coef),
    .out_idx  (out_idx),
    .out_comp (out_comp),
    .out_last (out_last),
    .err      (err)
  );

  always #5 clock = ~clock;

  // Capture each beat that will handshake at the coming rising edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready)
      beats.push_back('{int'($signed(out_coef)), int'(out_idx), int'(out_comp), int'(out_last)});
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input bit dc, input int comp, input int run, input int size,
                      input int val, input string tag);
    bit done;
    done     = 1'b0;
    in_dc    = dc;
    in_comp  = 2'(comp);
    in_run   = 4'(run);
    in_size  = 4'(size);
    in_value = 12'(val);
    in_valid = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) check({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_beats(input int n, input string tag);
    for (int c = 0; c < 2000 && beats.size() < n; c++) begin
      @(posedge clock);
      #2;
    end
    check({tag, "_beats"}, beats.size(), n);
  endtask

  task automatic set_exp(input int dc);
    for (int k = 0; k < 64; k++) exp_coef[k] = 0;
    exp_coef[0] = dc;
  endtask

  // Counts beats in one block that differ in idx, coef, comp or last flag.
  task automatic check_block(input int base, input int comp, input string tag);
    int bad;
    bad = 0;
    if (beats.size() < base + 64) begin
      bad = 1000;
    end else begin
      for (int k = 0; k < 64; k++) begin
        if (beats[base+k].idx  != k)                 bad++;
        if (beats[base+k].coef != exp_coef[k])       bad++;
        if (beats[base+k].comp != comp)              bad++;
        if (beats[base+k].last != ((k == 63) ? 1 : 0)) bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  // Holds out_ready low for five cycles; caller is positioned just after a rising edge.
  task automatic stall5(input string tag, input int want_ready);
    int idx0;
    int coef0;
    out_ready = 1'b0;
    @(negedge clock);
    idx0  = int'(out_idx);
    coef0 = int'($signed(out_coef));
    repeat (5) @(negedge clock);
    check({tag, "_idx_hold"}, int'(out_idx), idx0);
    check({tag, "_coef_hold"}, int'($signed(out_coef)), coef0);
    check({tag, "_valid_hold"}, int'(out_valid), 1);
    check({tag, "_in_ready"}, int'(in_ready), want_ready);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
  endtask

  int dc_comp [6] = '{0, 1, 0, 0, 0, 3};
  int dc_diff [6] = '{10, 4, 1, 2, 5, 1};
  int dc_rst  [6] = '{0, 0, 0, 1, 0, 0};
  int dc_exp  [6] = '{10, 4, 11, 2, 7, 8};

  initial begin
    reset_n   = 1'b0;
    restart   = 1'b0;
    in_valid  = 1'b0;
    in_dc     = 1'b0;
    in_comp   = '0;
    in_run    = '0;
    in_size   = '0;
    in_value  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_err", int'(err), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("idle_in_ready", int'(in_ready), 1);

    // Two comp-0 blocks: DC +5 then -3, each closed by EOB.
    send(1, 0, 0, 3, 5, "t1_dc_a");
    check("t1_latency_valid", int'(out_valid), 1);
    check("t1_latency_idx", int'(out_idx), 0);
    send(0, 0, 0, 0, 0, "t1_eob_a");
    send(1, 0, 0, 2, -3, "t1_dc_b");
    send(0, 0, 0, 0, 0, "t1_eob_b");
    wait_beats(128, "t1");
    repeat (5) @(posedge clock);
    #2;
    check("t1_total_beats", beats.size(), 128);
    set_exp(5);
    check_block(0, 0, "t1_block_a");
    set_exp(2);
    check_block(64, 0, "t1_block_b");

    // Runs with pending values.
    beats.delete();
    send(1, 0, 0, 0, 0, "t2_dc");
    send(0, 0, 2, 3, 7, "t2_ac_a");
    send(0, 0, 0, 1, -1, "t2_ac_b");
    send(0, 0, 0, 0, 0, "t2_eob");
    wait_beats(64, "t2");
    set_exp(2);
    exp_coef[3] = 7;
    exp_coef[4] = -1;
    check_block(0, 0, "t2_block");
    check("t2_err", int'(err), 0);

    // Block closed by a value landing on idx 63, no EOB.
    beats.delete();
    send(1, 0, 0, 0, 0, "t3_dc");
    repeat (3) send(0, 0, 15, 0, 0, "t3_zrl");
    send(0, 0, 14, 4, 9, "t3_ac");
    wait_beats(64, "t3");
    set_exp(2);
    exp_coef[63] = 9;
    check_block(0, 0, "t3_block");
    check("t3_in_ready", int'(in_ready), 1);
    check("t3_err", int'(err), 0);

    // Backpressure: stall with idx0 held, then mid-fill.
    beats.delete();
    send(1, 0, 0, 1, 1, "t5_dc");
    stall5("t5_stall_ac", 0);
    send(0, 0, 3, 2, -2, "t5_ac");
    send(0, 0, 0, 0, 0, "t5_eob");
    wait_beats(20, "t5_mid");
    stall5("t5_stall_fill", 0);
    wait_beats(64, "t5");
    set_exp(3);
    exp_coef[4] = -2;
    check_block(0, 0, "t5_block");

    // Overflow: 60 zeros plus value at 61, then a run past 63.
    beats.delete();
    send(1, 0, 0, 0, 0, "t4_dc");
    repeat (3) send(0, 0, 15, 0, 0, "t4_zrl");
    send(0, 0, 12, 3, 4, "t4_ac_a");
    check("t4_err_before", int'(err), 0);
    send(0, 0, 5, 2, 3, "t4_ac_ovf");
    wait_beats(64, "t4");
    set_exp(3);
    exp_coef[61] = 4;
    check_block(0, 0, "t4_block");
    check("t4_err_set", int'(err), 1);
    check("t4_in_ready", int'(in_ready), 1);

    // Interleaved components, restart, out-of-range component id.
    restart = 1'b1;
    @(posedge clock);
    #1;
    restart = 1'b0;
    for (int b = 0; b < 6; b++) begin
      beats.delete();
      restart = dc_rst[b][0];
      send(1, dc_comp[b], 0, 4, dc_diff[b], "t6_dc");
      restart = 1'b0;
      send(0, 0, 0, 0, 0, "t6_eob");
      wait_beats(64, "t6");
      set_exp(dc_exp[b]);
      check_block(0, dc_comp[b], $sformatf("t6_block%0d", b));
    end
    check("t6_err_sticky", int'(err), 1);

    // Reset mid-block.
    beats.delete();
    send(1, 0, 0, 1, 1, "t7_dc");
    send(0, 0, 0, 0, 0, "t7_eob");
    wait_beats(10, "t7_mid");
    #1;
    reset_n = 1'b0;
    #1;
    check("t7_rst_valid", int'(out_valid), 0);
    check("t7_rst_err", int'(err), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    beats.delete();
    send(1, 0, 0, 3, 6, "t7_dc2");
    send(0, 0, 0, 0, 0, "t7_eob2");
    wait_beats(64, "t7");
    set_exp(6);
    check_block(0, 0, "t7_block");

    // AC symbol while waiting for DC is dropped and flags err.
    beats.delete();
    send(0, 0, 0, 1, 1, "t8_stray_ac");
    repeat (4) @(posedge clock);
    #2;
    check("t8_err", int'(err), 1);
    check("t8_no_beats", beats.size(), 0);
    send(1, 0, 0, 1, 1, "t8_dc");
    send(0, 0, 0, 0, 0, "t8_eob");
    wait_beats(64, "t8");
    set_exp(7);
    check_block(0, 0, "t8_block");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_block_builder.md
Name: coef_block_builder

Overview:
- Sits directly downstream of the VLI decoder in the entropy-decode path.
- Consumes decoded (run, size, value) symbols and expands them into a serial stream of exactly 64 quantized coefficients per 8x8 block, in zigzag index order.
- Applies the DC differential predictor per colour component.
- Feeds the dequantizer / inverse-zigzag stage through a valid/ready handshake.

Parameters:
- NUM_COMP, 3, number of colour components with independent DC predictors (1..4).
- COEF_W, 12, signed coefficient width; matches the VLI decoder output.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- restart  input  1  synchronous pulse; clears all DC predictors to 0 (restart marker).
- in_valid  input  1  symbol valid.
- in_ready  output  1  block can accept a symbol this cycle.
- in_dc  input  1  1 = DC symbol, 0 = AC symbol.
- in_comp  input  2  component id of the symbol; sampled on DC symbols only.
- in_run  input  4  AC zero-run length; ignored when in_dc=1.
- in_size  input  4  VLI size; AC size 0 with run 0 = EOB, run 15 = ZRL.
- in_value  input  COEF_W  signed decoded value (DC difference or AC coefficient).
- out_valid  output  1  coefficient valid.
- out_ready  input  1  downstream accepts the coefficient.
- out_coef  output  COEF_W  signed coefficient.
- out_idx  output  6  zigzag index, 0..63.
- out_comp  output  2  component id of the current block.
- out_last  output  1  high with idx 63.
- err  output  1  sticky run-overflow flag; cleared only by reset_n.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - outputs: out_valid=0, out_coef=0, out_idx=0, out_comp=0, out_last=0, err=0.
  - internal: state=S_DC, next_idx=0, all predictors 0.
  - If reset asserts mid-block, the partial block is discarded; the next symbol accepted after reset must be a DC symbol.
- Output register is one deep. "Slot free" means out_valid=0 or out_ready=1. Output fields hold stable while out_valid=1 and out_ready=0.
- in_ready=1 only when state is S_DC or S_AC and the slot is free. A symbol is accepted when in_valid && in_ready.
- Latency: a symbol accepted in cycle N produces its first coefficient with out_valid=1 in cycle N+1. Under continuous out_ready, one coefficient is emitted per cycle.
- States:
  - S_DC (accept DC):
    - coef = pred[in_comp] + in_value, COEF_W-bit two's-complement wrap.
    - pred[in_comp] <= coef; emit at idx 0; latch out_comp.
    - next_idx <= 1; go to S_AC.
    - An AC symbol presented in S_DC is accepted and dropped, and sets err.
  - S_AC (accept AC):
    - EOB: go to S_FILL.
    - ZRL: zero_cnt=16, no value; go to S_ZERO.
    - Other symbols: zero_cnt=in_run, pending value latched; go to S_ZERO, or straight to the value emit when run=0.
    - A DC symbol presented in S_AC is dropped and sets err.
  - S_ZERO: emit 0 per slot, decrement zero_cnt; then emit the pending value if one exists (S_VAL); otherwise return to S_AC.
  - S_FILL: emit 0 at each index up to 63.
- Block completion: emitting idx 63 (by any path) asserts out_last and returns the FSM to S_DC. No EOB is expected after a full block; a ZRL starting at next_idx=48 ends the block legally.
- Overflow: if next_idx + zeros (+1 if value) > 64:
  - set err; emit zeros through idx 63 with out_last; drop the value; return to S_DC.
- Arithmetic:
  - next_idx is 7 bits internally so 64 can be compared.
  - Predictors are COEF_W bits, indexed by in_comp. An in_comp value >= NUM_COMP uses predictor 0.
- restart:
  - Clears all predictors in the cycle it is sampled.
  - If restart coincides with an accepted DC symbol, that DC uses prediction 0, and the predictor stores in_value.
- Simultaneous events: a new symbol is accepted in the same cycle the previous symbol's final coefficient handshakes, provided the slot is free. No bubble is required.

Test Plan:
1. comp0 DC diff +5, EOB; then comp0 DC diff -3, EOB:
   - block1: idx0=5, idx1..63=0, out_last at idx63.
   - block2: idx0=2.
   - exactly 128 output beats.
2. DC diff 0, AC run=2 value=7, AC run=0 value=-1, EOB -> idx1=0, idx2=0, idx3=7, idx4=-1, idx5..63=0, err=0.
3. Three ZRLs (48 zeros) then a single AC run=14 value=9 -> idx1..62=0, idx63=9, out_last=1, FSM back to S_DC with no EOB, in_ready=1.
4. Overflow: after 60 zeros via ZRLs plus run=12, send AC run=5 value=3 -> idx up to 63 all zero, value 3 never emitted, err=1 and stays 1.
5. Backpressure: hold out_ready=0 for 5 cycles mid-run -> out_coef and out_idx stable, in_ready=0; on release, the stream resumes with no lost or duplicated indices.
6. Interleaved comps: Y DC+10, Cb DC+4, Y DC+1, then restart, Y DC+2 (each followed by EOB) -> DC coefficients 10, 4, 11, 2. Assert reset_n mid-block -> out_valid=0 immediately and the next block starts at idx0.
